adc_cfg_wr_arbiter: RTL
=======================

// Module: adc_cfg_wr_arbiter
// PURPOSE
//  Shares the 32x24 ADC configuration memory write port between NREQ requesters
//  (0=JTAG, 1=ChipScope, 2=slow control) with round-robin priority. Locks out
//  writes while an ADC configuration sequence is running. Issues a one-cycle
//  INIT pulse to the ADC configuration FSM after a write burst settles, or on command.
// PARAMETERS
//  NREQ      3      number of write requesters
//  LAST_ADDR 5'h10  highest valid memory address; above it = rejected
//  HOLDOFF   64     idle cycles after last accepted write before auto INIT
//  TIMEOUT   4096   max cycles from INIT to CFG_DONE re-asserted
// PORTS
//  CLK        in   1         system clock
//  RST_N      in   1         synchronous reset, active low
//  REQ        in   NREQ      write request per requester, held until ACK
//  REQ_ADDR   in   5*NREQ    packed write addresses, requester i at [5i+4:5i]
//  REQ_DATA   in   24*NREQ   packed write data, requester i at [24i+23:24i]
//  ACK        out  NREQ      1-cycle accept pulse, one-hot
//  NACK       out  NREQ      1-cycle reject pulse (address > LAST_ADDR)
//  WE         out  1         memory write enable
//  WADDR      out  5         memory write address
//  WDATA      out  24        memory write data
//  AUTO_INIT  in   1         enable INIT after a write burst
//  INIT_CMD   in   1         request a configuration (level; edge detected)
//  CFG_DONE   in   1         DONE from the ADC configuration FSM
//  INIT       out  1         1-cycle pulse to the configuration FSM
//  BUSY       out  1         high in INIT_PULSE and WAIT_LOW/WAIT_HIGH
//  TMO_ERR    out  1         sticky: configuration did not finish in TIMEOUT cycles
// BEHAVIOUR
//  Reset: ACK=NACK=0, WE=0, WADDR=0, WDATA=0, INIT=0, BUSY=0, TMO_ERR=0.
//   State=IDLE, RR pointer=0, init_pend=0, holdoff counter cleared.
//   Reset mid-sequence discards the pending INIT and any in-flight grant.
//  States: IDLE -> WRITE -> IDLE.
//   IDLE -> INIT_PULSE -> WAIT_LOW -> WAIT_HIGH -> IDLE.
//  IDLE with any REQ: RR picks the first requester at or after the pointer.
//   The next cycle is WRITE: ACK[i]=1 with WE=1, WADDR/WDATA = that requester's
//   request, registered. Latency is 1 cycle from REQ sampled to WE/ACK.
//   The pointer moves to i+1 mod NREQ.
//   If addr>LAST_ADDR: NACK[i]=1, WE=0, pointer still advances, no holdoff reload.
//  Handshake: a requester must drop REQ the cycle after ACK/NACK or present a new
//   write. A REQ still high in the cycle after WRITE is treated as a new request.
//   Back-to-back accepts are therefore at most 1 per 2 cycles.
//  Accepted write: reloads the holdoff counter to HOLDOFF-1. If AUTO_INIT=1, sets init_pend.
//  INIT_CMD rising edge: sets init_pend. It does not reload holdoff.
//   It is honoured once holdoff expires.
//  IDLE, init_pend=1, holdoff=0, no REQ: go to INIT_PULSE.
//   INIT=1 for 1 cycle; clear init_pend; load the timeout counter.
//   Writes take priority over a pending INIT.
//  WAIT_LOW: wait for CFG_DONE=0. Then WAIT_HIGH: wait for CFG_DONE=1, then IDLE.
//  Timeout counter expires in WAIT_LOW or WAIT_HIGH: set TMO_ERR, go to IDLE.
//   TMO_ERR clears only on reset.
//  REQ during BUSY is not acknowledged; it is served after return to IDLE.
//  INIT_CMD edge during BUSY: sets init_pend, giving exactly one further configuration.
//  Holdoff counter saturates at 0. Timeout counter width is clog2(TIMEOUT).
// CONFIGURATION
//  ADC_CFG_ARB_STATS_EN defined: adds outputs WR_CNT[15:0] and INIT_CNT[7:0].
//   WR_CNT counts accepted writes; INIT_CNT counts INIT pulses.
//   Both are reset to 0 and wrap at full scale.
//  Undefined: these ports and counters are absent. All other behaviour is identical.
// STRUCTURE
//  Package adc_cfg_pkg:
//   state encoding IDLE/WRITE/INIT_PULSE/WAIT_LOW/WAIT_HIGH;
//   ADC_CFG_AW=5, ADC_CFG_DW=24, ADC_CFG_LAST_ADDR=5'h10;
//   requester indices REQ_JTAG=0, REQ_CSP=1, REQ_SC=2.
//  Sub-module rr_arb #(N): combinational round-robin select.
//   Inputs: request vector and pointer. Outputs: one-hot grant and index.
//  Main FSM, counters and datapath registers stay in adc_cfg_wr_arbiter.
// TESTING
//  REQ=3'b111 with addrs 1,2,3 held until acked -> ACK order 0,1,2.
//   WE on cycles 1,3,5 with matching WADDR/WDATA.
//  REQ[1] addr=5'h11 -> NACK[1] pulse, WE never asserted, INIT not issued.
//  AUTO_INIT=1, one write, HOLDOFF=64 -> INIT pulse 65 cycles after WE.
//   A second write at cycle 30 delays INIT to 65 cycles after that write.
//  INIT sent, CFG_DONE falls at +3 and rises at +500 -> BUSY for that span.
//   A REQ raised during BUSY is acked 1 cycle after IDLE.
//  CFG_DONE stuck high after INIT with TIMEOUT=4096 -> TMO_ERR=1 at +4096.
//   State returns to IDLE.
//  RST_N low in WAIT_HIGH with init_pend set -> all outputs 0 next cycle.
//   No INIT after reset is released.

Source files
------------

// File: rtl/adc_cfg_pkg.sv
// adc_cfg_pkg
//   Shared definitions for the ADC configuration-memory write arbiter:
//   memory geometry, requester indices and the arbiter state encoding.
package adc_cfg_pkg;

  localparam int ADC_CFG_AW = 5;
  localparam int ADC_CFG_DW = 24;
  localparam logic [ADC_CFG_AW-1:0] ADC_CFG_LAST_ADDR = 5'h10;

  // Requester slots on the REQ vector
  localparam int REQ_JTAG = 0;
  localparam int REQ_CSP  = 1;
  localparam int REQ_SC   = 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WRITE      = 3'd1,
    INIT_PULSE = 3'd2,
    WAIT_LOW   = 3'd3,
    WAIT_HIGH  = 3'd4
  } adc_cfg_state_e;

  // States in which a configuration sequence owns the memory
  function automatic logic is_busy_state(input adc_cfg_state_e s);
    return (s == INIT_PULSE) || (s == WAIT_LOW) || (s == WAIT_HIGH);
  endfunction

endpackage

// File: rtl/adc_cfg_wr_arbiter_rr_arb.sv
// rr_arb
//   Combinational round-robin select. Scans the request vector starting at
//   ptr and wrapping, and grants the first active requester.
//   Ports:
//     req  in  N       request vector
//     ptr  in  IW      first index to consider (must be < N)
//     gnt  out N       one-hot grant (all zero when no request)
//     idx  out IW      index of the granted requester
//     vld  out 1       any request present
module rr_arb #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    c   = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!vld && req[c]) begin
        vld    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/adc_cfg_wr_arbiter.sv
// adc_cfg_wr_arbiter
//   Shares the 32x24 ADC configuration memory write port between NREQ
//   requesters (0=JTAG, 1=ChipScope, 2=slow control) with round-robin
//   priority, locks out writes while a configuration sequence runs, and
//   issues a one-cycle INIT to the ADC configuration FSM once a write burst
//   has settled (AUTO_INIT) or on an INIT_CMD rising edge.
//
//   Ports:
//     CLK, RST_N        clock, synchronous active-low reset
//     REQ/REQ_ADDR/REQ_DATA  per-requester write request, packed 5/24 bits
//     ACK/NACK          one-cycle accept / reject (addr > LAST_ADDR) pulses
//     WE/WADDR/WDATA    registered memory write port
//     AUTO_INIT         arm an INIT after each accepted write
//     INIT_CMD          configuration request level (rising edge used)
//     CFG_DONE          DONE from the configuration FSM
//     INIT              one-cycle configuration start pulse
//     BUSY              configuration sequence in progress
//     TMO_ERR           sticky: configuration did not finish in TIMEOUT cycles
//
//   Build option: define ADC_CFG_ARB_STATS_EN to add WR_CNT[15:0] (accepted
//   writes) and INIT_CNT[7:0] (INIT pulses), both wrapping.
module adc_cfg_wr_arbiter
  import adc_cfg_pkg::*;
#(
  parameter int                    NREQ      = 3,
  parameter logic [ADC_CFG_AW-1:0] LAST_ADDR = ADC_CFG_LAST_ADDR,
  parameter int                    HOLDOFF   = 64,
  parameter int                    TIMEOUT   = 4096
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [NREQ-1:0]              REQ,
  input  logic [ADC_CFG_AW*NREQ-1:0]   REQ_ADDR,
  input  logic [ADC_CFG_DW*NREQ-1:0]   REQ_DATA,
  output logic [NREQ-1:0]              ACK,
  output logic [NREQ-1:0]              NACK,
  output logic                         WE,
  output logic [ADC_CFG_AW-1:0]        WADDR,
  output logic [ADC_CFG_DW-1:0]        WDATA,
  input  logic                         AUTO_INIT,
  input  logic                         INIT_CMD,
  input  logic                         CFG_DONE,
  output logic                         INIT,
  output logic                         BUSY,
  output logic                         TMO_ERR
`ifdef ADC_CFG_ARB_STATS_EN
  , output logic [15:0]                WR_CNT
  , output logic [7:0]                 INIT_CNT
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT - 1);

  adc_cfg_state_e        state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [NREQ-1:0]       ack_q, ack_d;
  logic [NREQ-1:0]       nack_q, nack_d;
  logic                  we_q, we_d;
  logic [ADC_CFG_AW-1:0] waddr_q, waddr_d;
  logic [ADC_CFG_DW-1:0] wdata_q, wdata_d;
  logic                  init_q, init_d;
  logic                  busy_q, busy_d;
  logic                  tmo_err_q, tmo_err_d;
  logic                  init_pend_q, init_pend_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  init_cmd_q;

  logic [NREQ-1:0]       gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_vld;
  logic [ADC_CFG_AW-1:0] sel_addr;
  logic [ADC_CFG_DW-1:0] sel_data;
  logic                  init_cmd_rise;

  rr_arb #(.N(NREQ)) u_rr_arb (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gnt_idx),
    .vld (gnt_vld)
  );

  assign sel_addr      = REQ_ADDR[int'(gnt_idx)*ADC_CFG_AW +: ADC_CFG_AW];
  assign sel_data      = REQ_DATA[int'(gnt_idx)*ADC_CFG_DW +: ADC_CFG_DW];
  assign init_cmd_rise = INIT_CMD & ~init_cmd_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ack_d       = '0;
    nack_d      = '0;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    init_d      = 1'b0;
    tmo_err_d   = tmo_err_q;
    init_pend_d = init_pend_q;
    hold_d      = (hold_q != '0) ? hold_q - HW'(1) : '0;
    tmo_d       = (tmo_q != '0) ? tmo_q - TW'(1) : '0;

    // Holdoff restarts from the cycle the write reaches the memory, so the
    // auto INIT lands HOLDOFF+1 cycles after WE.
    if (state_q == WRITE && we_q) begin
      hold_d = HOLD_LOAD;
      if (AUTO_INIT) init_pend_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        // Writes win over a pending INIT
        if (gnt_vld) begin
          state_d = WRITE;
          ptr_d   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IW'(1);
          if (sel_addr > LAST_ADDR) begin
            nack_d = gnt;
          end else begin
            ack_d   = gnt;
            we_d    = 1'b1;
            waddr_d = sel_addr;
            wdata_d = sel_data;
          end
        end else if (init_pend_q && hold_q == '0) begin
          state_d     = INIT_PULSE;
          init_d      = 1'b1;
          init_pend_d = 1'b0;
          tmo_d       = TMO_LOAD;
        end
      end
      // REQ is ignored here; a REQ still high next cycle is a new request
      WRITE:      state_d = IDLE;
      INIT_PULSE: state_d = WAIT_LOW;
      WAIT_LOW: begin
        if (!CFG_DONE) begin
          state_d = WAIT_HIGH;
        end else if (tmo_q == '0) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (CFG_DONE) begin
          state_d = IDLE;
        end else if (tmo_q == '0) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An edge in the same cycle as the INIT decision re-arms for one more run
    if (init_cmd_rise) init_pend_d = 1'b1;

    busy_d = is_busy_state(state_d);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      ack_q       <= '0;
      nack_q      <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      init_q      <= 1'b0;
      busy_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      init_pend_q <= 1'b0;
      hold_q      <= '0;
      tmo_q       <= '0;
      // Track the level through reset so a command held high across reset
      // release is not mistaken for a new edge.
      init_cmd_q  <= INIT_CMD;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      nack_q      <= nack_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      init_q      <= init_d;
      busy_q      <= busy_d;
      tmo_err_q   <= tmo_err_d;
      init_pend_q <= init_pend_d;
      hold_q      <= hold_d;
      tmo_q       <= tmo_d;
      init_cmd_q  <= INIT_CMD;
    end
  end

  assign ACK     = ack_q;
  assign NACK    = nack_q;
  assign WE      = we_q;
  assign WADDR   = waddr_q;
  assign WDATA   = wdata_q;
  assign INIT    = init_q;
  assign BUSY    = busy_q;
  assign TMO_ERR = tmo_err_q;

`ifdef ADC_CFG_ARB_STATS_EN
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [7:0]  init_cnt_q, init_cnt_d;

  always_comb begin
    wr_cnt_d   = wr_cnt_q + {15'd0, we_q};
    init_cnt_d = init_cnt_q + {7'd0, init_q};
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_cnt_q   <= '0;
      init_cnt_q <= '0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  assign WR_CNT   = wr_cnt_q;
  assign INIT_CNT = init_cnt_q;
`else
  // Statistics counters not built
`endif

endmodule
